ledrx: RTL and testbench
========================

# ledrx

Receive-side decoder for the tricolor LED strip protocol. It samples the strip's `mosi`/`sck` pins in its own clock domain and locks onto the 32-bit all-zero start frame. It then decodes each 32-bit LED frame (header, blue, green, red) into parallel colour bytes with a valid strobe and LED index, and flags the all-ones end frame. It serves two roles: the loopback/monitor checker behind the LED driver chain, and the input stage of a daisy-chained strip emulator.

## Interface
- `INDEX_WIDTH`, 8: width of `led_index`, which saturates at all-ones.
- `IDLE_TIMEOUT`, 1024: number of `ledrx_clk` cycles without a rising `sck` edge, mid-word, before the current word is aborted.
- `ledrx_clk`  in  1  sole clock. One clock; reset is asynchronous and active-low.
- `ledrx_rst_n`  in  1  asynchronous, active-low reset.
- `mosi`  in  1  strip data, asynchronous to `ledrx_clk`, MSB first.
- `sck`  in  1  strip clock, asynchronous; data is valid on its rising edge.
- `blue_output`  out  8  last decoded blue byte.
- `green_output`  out  8  last decoded green byte.
- `red_output`  out  8  last decoded red byte.
- `brightness_output`  out  5  last decoded header bits [4:0].
- `led_index`  out  INDEX_WIDTH  0-based position of the LED just decoded.
- `led_valid`  out  1  one-cycle pulse; the colour outputs and `led_index` are new.
- `frame_start`  out  1  one-cycle pulse; a start frame was recognised.
- `frame_end`  out  1  one-cycle pulse; an end frame was recognised.
- `header_error`  out  1  one-cycle pulse; a word had a bad header.
- `ledrx_busy`  out  1  high while in WORD state.

## Operation
- **Pin conditioning.** `sck` and `mosi` each pass through a 2-flop synchronizer. A third `sck` flop provides edge detection. A bit is taken from synchronized `mosi` on each detected rising `sck` edge.
- **State HUNT.**
  - A zero-run counter (6 bits, saturating at 32) counts consecutive received 0 bits and clears on any 1.
  - When the count reaches 32: pulse `frame_start`, set `led_index` to 0, clear the bit counter, and go to WORD.
- **State WORD.** Shift bits into a 32-bit register; a 5-bit bit counter runs 0..31. On the 32nd bit, classify the assembled word:
  - 0x00000000: another start frame. Pulse `frame_start`, reset `led_index` to 0, stay in WORD.
  - 0xFFFFFFFF: end frame. Pulse `frame_end`, go to HUNT.
    - A header-0xFF LED word with all colours 0xFF is also classified as the end frame, by design.
  - Header bits [31:29] = 3'b111 (all other words): LED frame.
    - Load blue = [23:16], green = [15:8], red = [7:0], brightness = [28:24].
    - Pulse `led_valid` with the current `led_index`, then increment the index, saturating at all-ones.
    - Stay in WORD.
  - Any other word: pulse `header_error`, go to HUNT with the zero-run counter cleared.
- **Timeout.**
  - In WORD, a timeout counter clears on every rising `sck` edge.
  - Reaching `IDLE_TIMEOUT` with bit counter ≠ 0: abort to HUNT. Discard the partial word, assert no pulses, leave the outputs held.
  - With bit counter = 0 (between words), no timeout applies; WORD is held indefinitely.
- The colour, brightness and index outputs hold their values until the next `led_valid`.

## Timing
- Reset value of every output is 0. Reset also forces HUNT and clears all counters and the shift register. Reset asserted mid-word discards that word.
- Fixed latency: each pulse asserts exactly 4 `ledrx_clk` rising edges after the first edge that samples the 32nd bit's `sck` high at the synchronizer input.
- Pulses last exactly 1 cycle. At most one of `led_valid`, `frame_start`, `frame_end`, `header_error` is high in any cycle.
- Input constraint: `sck` high and low phases must each be ≥ 3 `ledrx_clk` periods. `mosi` must be stable from 2 periods before to 2 periods after the rising `sck` edge.
- Simultaneous events: a rising `sck` edge and a timeout expiry in the same cycle resolve in favour of the edge. The bit is accepted and the timeout counter clears.
- An `sck` edge in the same cycle as a classification pulse is the first bit of the next word.

## Structure
- Shared package `led_pkg`, also used by the LED driver:
  - frame-type constants: START_WORD = 32'h0, END_WORD = 32'hFFFFFFFF, HEADER_MARK = 3'b111;
  - `ledrx` state encoding: HUNT = 0, WORD = 1.
- One sub-module, `spi_pin_sync`. It holds the 2-flop synchronizers for `sck`/`mosi` plus the rising-edge detector, and outputs `bit_strobe` and `bit_value`.
- The word classifier and counters stay in `ledrx`.

## Test plan
- Send 32 zero bits, then LED word 0xFF102030 → `frame_start`, then `led_valid` with blue 0x10, green 0x20, red 0x30, brightness 0x1F, `led_index` 0.
- Send start, three LED words, then 0xFFFFFFFF → `led_valid` with indices 0, 1, 2, then `frame_end`; `ledrx_busy` falls to 0.
- Send 17 zeros, a 1, then 32 zeros → exactly one `frame_start`, 4 cycles after the 32nd zero after the 1.
- Send start, then word 0x5F000000 → `header_error`, back to HUNT; a following LED word produces no `led_valid`.
- Send start, then 12 bits; stall `sck` for `IDLE_TIMEOUT` cycles; send start and LED 0xE1AABBCC → no error pulse, then `led_valid` with brightness 0x01, blue 0xAA, index 0.
- With `INDEX_WIDTH` = 2, send start and 6 LED words → indices 0, 1, 2, 3, 3, 3; assert `ledrx_rst_n` low mid-word → all outputs 0 immediately.

Source files
------------

// File: rtl/led_pkg.sv
// Shared definitions for the tricolor LED strip driver and receiver.
// Frame constants, receiver state encoding and the word classifier.
package led_pkg;

    localparam logic [31:0] START_WORD  = 32'h0000_0000;
    localparam logic [31:0] END_WORD    = 32'hFFFF_FFFF;
    localparam logic [2:0]  HEADER_MARK = 3'b111;

    typedef enum logic {
        HUNT = 1'b0,
        WORD = 1'b1
    } ledrx_state_t;

    typedef enum logic [1:0] {
        WK_START,
        WK_END,
        WK_LED,
        WK_BAD
    } word_kind_t;

    // END_WORD also carries the LED header mark, so it is tested first.
    function automatic word_kind_t classify_word(input logic [31:0] w);
        if (w == START_WORD) begin
            return WK_START;
        end else if (w == END_WORD) begin
            return WK_END;
        end else if (w[31:29] == HEADER_MARK) begin
            return WK_LED;
        end
        return WK_BAD;
    endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Synchronizes the strip sck/mosi pins into the local clock domain
// and emits one registered strobe per rising sck edge.
module spi_pin_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic sck,
    input  logic mosi,
    output logic bit_strobe,
    output logic bit_value
);

    logic [1:0] sck_sync;
    logic [1:0] mosi_sync;
    logic       sck_dly;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync   <= 2'b00;
            mosi_sync  <= 2'b00;
            sck_dly    <= 1'b0;
            bit_strobe <= 1'b0;
            bit_value  <= 1'b0;
        end else begin
            sck_sync   <= {sck_sync[0], sck};
            mosi_sync  <= {mosi_sync[0], mosi};
            sck_dly    <= sck_sync[1];
            bit_strobe <= sck_sync[1] & ~sck_dly;
            bit_value  <= mosi_sync[1];
        end
    end

endmodule

// File: rtl/ledrx.sv
// Receive-side decoder for the tricolor LED strip: locks on the start
// frame, decodes LED words into colour bytes and flags end frames.
module ledrx
    import led_pkg::*;
#(
    parameter int INDEX_WIDTH  = 8,
    parameter int IDLE_TIMEOUT = 1024
) (
    input  logic                   ledrx_clk,
    input  logic                   ledrx_rst_n,
    input  logic                   mosi,
    input  logic                   sck,
    output logic [7:0]             blue_output,
    output logic [7:0]             green_output,
    output logic [7:0]             red_output,
    output logic [4:0]             brightness_output,
    output logic [INDEX_WIDTH-1:0] led_index,
    output logic                   led_valid,
    output logic                   frame_start,
    output logic                   frame_end,
    output logic                   header_error,
    output logic                   ledrx_busy
);

    localparam int TW = $clog2(IDLE_TIMEOUT + 1);

    ledrx_state_t           state;
    ledrx_state_t           state_nxt;
    logic                   bit_strobe;
    logic                   bit_value;
    logic [5:0]             zero_run;
    logic [4:0]             bit_cnt;
    logic [31:0]            shreg;
    logic                   word_rdy;
    logic [TW-1:0]          tmo_cnt;
    logic [INDEX_WIDTH-1:0] idx;
    word_kind_t             kind;
    logic                   hunt_hit;
    logic                   tmo_hit;
    logic                   start_nxt;
    logic                   end_nxt;
    logic                   valid_nxt;
    logic                   err_nxt;

    spi_pin_sync u_sync (
        .clk        (ledrx_clk),
        .rst_n      (ledrx_rst_n),
        .sck        (sck),
        .mosi       (mosi),
        .bit_strobe (bit_strobe),
        .bit_value  (bit_value)
    );

    assign kind       = classify_word(shreg);
    assign hunt_hit   = (state == HUNT) && (zero_run == 6'd32);
    assign ledrx_busy = (state == WORD);

    // A sck edge in the expiry cycle wins over the timeout.
    assign tmo_hit = (state == WORD) && (bit_cnt != 5'd0) && !bit_strobe
                  && (tmo_cnt == TW'(IDLE_TIMEOUT - 1));

    always_ff @(posedge ledrx_clk or negedge ledrx_rst_n) begin
        if (!ledrx_rst_n) begin
            state <= HUNT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        start_nxt = 1'b0;
        end_nxt   = 1'b0;
        valid_nxt = 1'b0;
        err_nxt   = 1'b0;
        unique case (state)
            HUNT: begin
                if (hunt_hit) begin
                    start_nxt = 1'b1;
                    state_nxt = WORD;
                end
            end
            WORD: begin
                if (word_rdy) begin
                    unique case (kind)
                        WK_START: start_nxt = 1'b1;
                        WK_END: begin
                            end_nxt   = 1'b1;
                            state_nxt = HUNT;
                        end
                        WK_LED:   valid_nxt = 1'b1;
                        WK_BAD: begin
                            err_nxt   = 1'b1;
                            state_nxt = HUNT;
                        end
                    endcase
                end else if (tmo_hit) begin
                    state_nxt = HUNT;
                end
            end
        endcase
    end

    always_ff @(posedge ledrx_clk or negedge ledrx_rst_n) begin
        if (!ledrx_rst_n) begin
            zero_run <= 6'd0;
        end else if (state != HUNT || state_nxt != HUNT) begin
            zero_run <= 6'd0;
        end else if (bit_strobe) begin
            if (bit_value) begin
                zero_run <= 6'd0;
            end else if (zero_run != 6'd32) begin
                zero_run <= zero_run + 6'd1;
            end
        end
    end

    always_ff @(posedge ledrx_clk or negedge ledrx_rst_n) begin
        if (!ledrx_rst_n) begin
            bit_cnt  <= 5'd0;
            shreg    <= 32'd0;
            word_rdy <= 1'b0;
        end else begin
            word_rdy <= 1'b0;
            if (state == WORD && bit_strobe) begin
                shreg    <= {shreg[30:0], bit_value};
                bit_cnt  <= bit_cnt + 5'd1;
                word_rdy <= (bit_cnt == 5'd31);
            end else if (state_nxt != state) begin
                bit_cnt <= 5'd0;
            end
        end
    end

    always_ff @(posedge ledrx_clk or negedge ledrx_rst_n) begin
        if (!ledrx_rst_n) begin
            tmo_cnt <= '0;
        end else if (state != WORD || bit_strobe || bit_cnt == 5'd0) begin
            tmo_cnt <= '0;
        end else if (tmo_cnt != '1) begin
            tmo_cnt <= tmo_cnt + TW'(1);
        end
    end

    always_ff @(posedge ledrx_clk or negedge ledrx_rst_n) begin
        if (!ledrx_rst_n) begin
            idx <= '0;
        end else if (start_nxt) begin
            idx <= '0;
        end else if (valid_nxt && idx != '1) begin
            idx <= idx + INDEX_WIDTH'(1);
        end
    end

    always_ff @(posedge ledrx_clk or negedge ledrx_rst_n) begin
        if (!ledrx_rst_n) begin
            blue_output       <= 8'd0;
            green_output      <= 8'd0;
            red_output        <= 8'd0;
            brightness_output <= 5'd0;
            led_index         <= '0;
            led_valid         <= 1'b0;
            frame_start       <= 1'b0;
            frame_end         <= 1'b0;
            header_error      <= 1'b0;
        end else begin
            led_valid    <= valid_nxt;
            frame_start  <= start_nxt;
            frame_end    <= end_nxt;
            header_error <= err_nxt;
            if (valid_nxt) begin
                brightness_output <= shreg[28:24];
                blue_output       <= shreg[23:16];
                green_output      <= shreg[15:8];
                red_output        <= shreg[7:0];
                led_index         <= idx;
            end
        end
    end

endmodule

// File: tb/tb_ledrx.sv
// Randomized bench for ledrx against a word-level protocol model.
// A second instance with a 2-bit index checks index saturation.
module tb_ledrx;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic mosi = 1'b0;
    logic sck = 1'b0;

    logic [7:0] a_blue, a_green, a_red;
    logic [4:0] a_bright;
    logic [7:0] a_index;
    logic a_valid, a_start, a_end, a_err, a_busy;

    logic [7:0] b_blue, b_green, b_red;
    logic [4:0] b_bright;
    logic [1:0] b_index;
    logic b_valid, b_start, b_end, b_err, b_busy;

    ledrx dut (
        .ledrx_clk         (clk),
        .ledrx_rst_n       (rst_n),
        .mosi              (mosi),
        .sck               (sck),
        .blue_output       (a_blue),
        .green_output      (a_green),
        .red_output        (a_red),
        .brightness_output (a_bright),
        .led_index         (a_index),
        .led_valid         (a_valid),
        .frame_start       (a_start),
        .frame_end         (a_end),
        .header_error      (a_err),
        .ledrx_busy        (a_busy)
    );

    ledrx #(.INDEX_WIDTH(2)) dut2 (
        .ledrx_clk         (clk),
        .ledrx_rst_n       (rst_n),
        .mosi              (mosi),
        .sck               (sck),
        .blue_output       (b_blue),
        .green_output      (b_green),
        .red_output        (b_red),
        .brightness_output (b_bright),
        .led_index         (b_index),
        .led_valid         (b_valid),
        .frame_start       (b_start),
        .frame_end         (b_end),
        .header_error      (b_err),
        .ledrx_busy        (b_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errs = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected events: kind 1=start 2=end 3=led 4=header error
    typedef struct {
        int         kind;
        logic [31:0] w;
        int         idx;
        int         cyc;
    } ev_t;
    ev_t q[$];

    bit          hunting = 1'b1;
    int          zrun = 0;
    int          nb = 0;
    int          idx = 0;
    logic [31:0] word = 32'd0;

    function automatic void push(int k, logic [31:0] w, int id, int c);
        ev_t e;
        e.kind = k;
        e.w = w;
        e.idx = id;
        e.cyc = c + 5;
        q.push_back(e);
    endfunction

    function automatic void model_bit(bit b, int c);
        if (hunting) begin
            zrun = b ? 0 : zrun + 1;
            if (zrun == 32) begin
                push(1, 32'd0, 0, c);
                hunting = 1'b0;
                idx = 0;
                nb = 0;
                zrun = 0;
            end
        end else begin
            word = {word[30:0], b};
            nb++;
            if (nb == 32) begin
                nb = 0;
                if (word == 32'd0) begin
                    push(1, word, 0, c);
                    idx = 0;
                end else if (word == 32'hFFFF_FFFF) begin
                    push(2, word, 0, c);
                    hunting = 1'b1;
                    zrun = 0;
                end else if (word[31:29] == 3'b111) begin
                    push(3, word, idx, c);
                    idx++;
                end else begin
                    push(4, word, 0, c);
                    hunting = 1'b1;
                    zrun = 0;
                end
            end
        end
    endfunction

    function automatic void model_abort();
        if (!hunting && nb != 0) begin
            hunting = 1'b1;
            zrun = 0;
            nb = 0;
        end
    endfunction

    function automatic int kind_of(logic [3:0] p);
        if (p[0]) return 3;
        if (p[1]) return 1;
        if (p[2]) return 2;
        return 4;
    endfunction

    logic [3:0] p;
    ev_t        e;
    always @(negedge clk) begin
        if (rst_n) begin
            p = {a_err, a_end, a_start, a_valid};
            if (p != 4'd0) begin
                chk("onehot", 64'($countones(p)), 64'd1);
                chk("dut2_pulse", {b_err, b_end, b_start, b_valid}, p);
                if (q.size() == 0) begin
                    chk("unexpected", p, 0);
                end else begin
                    e = q.pop_front();
                    chk("kind", kind_of(p), e.kind);
                    chk("latency", cyc, e.cyc);
                    if (e.kind == 3) begin
                        chk("bright", a_bright, e.w[28:24]);
                        chk("blue", a_blue, e.w[23:16]);
                        chk("green", a_green, e.w[15:8]);
                        chk("red", a_red, e.w[7:0]);
                        chk("index", a_index, (e.idx > 255) ? 255 : e.idx);
                        chk("index2", b_index, (e.idx > 3) ? 3 : e.idx);
                        chk("colour2", {b_bright, b_blue, b_green, b_red},
                            {a_bright, a_blue, a_green, a_red});
                    end
                end
            end else if (q.size() != 0 && cyc > q[0].cyc) begin
                chk("missing", q[0].kind, 0);
                void'(q.pop_front());
            end
        end
    end

    task automatic send_bit(input bit b);
        @(negedge clk);
        mosi = b;
        repeat (2) @(negedge clk);
        sck = 1'b1;
        model_bit(b, cyc);
        repeat (3) @(negedge clk);
        sck = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 31; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic sync_start();
        send_bit(1'b1);
        send_word(32'd0);
    endtask

    function automatic logic [31:0] rand_led();
        logic [31:0] r;
        r = $urandom();
        r[31:29] = 3'b111;
        return r;
    endfunction

    function automatic logic [31:0] rand_bad();
        logic [31:0] r;
        r = $urandom();
        if (r[31:29] == 3'b111) r[31] = 1'b0;
        if (r == 32'd0) r = 32'h4000_0001;
        return r;
    endfunction

    initial begin
        int sel;
        logic [31:0] w;
        repeat (3) @(negedge clk);
        chk("rst_a", {a_blue, a_green, a_red, a_bright, a_index,
                      a_valid, a_start, a_end, a_err, a_busy}, 0);
        chk("rst_b", {b_blue, b_green, b_red, b_bright, b_index,
                      b_valid, b_start, b_end, b_err, b_busy}, 0);
        rst_n = 1'b1;

        send_word(32'd0);
        send_word(32'hFF10_2030);
        repeat (10) @(negedge clk);
        chk("t1_colour", {a_bright, a_blue, a_green, a_red},
            {5'h1F, 8'h10, 8'h20, 8'h30});
        chk("t1_busy", a_busy, 1);

        send_word(32'd0);
        for (int i = 0; i < 3; i++) send_word(rand_led());
        send_word(32'hFFFF_FFFF);
        repeat (10) @(negedge clk);
        chk("t2_index", a_index, 2);
        chk("t2_busy", a_busy, 0);

        for (int i = 0; i < 17; i++) send_bit(1'b0);
        send_bit(1'b1);
        send_word(32'd0);
        repeat (10) @(negedge clk);
        chk("t3_busy", a_busy, 1);
        send_word(32'hFFFF_FFFF);

        sync_start();
        send_word(32'h5F00_0000);
        send_word(32'hFF10_2030);
        repeat (10) @(negedge clk);
        chk("t4_busy", a_busy, 0);

        sync_start();
        for (int i = 0; i < 12; i++) send_bit(1'($urandom_range(0, 1)));
        repeat (1044) @(negedge clk);
        model_abort();
        chk("t5_abort", a_busy, 0);
        sync_start();
        send_word(32'hE1AA_BBCC);
        repeat (10) @(negedge clk);
        chk("t5_led", {a_bright, a_blue, a_index}, {5'h01, 8'hAA, 8'h00});

        repeat (1500) @(negedge clk);
        chk("gap_busy", a_busy, 1);
        send_word(rand_led());
        repeat (10) @(negedge clk);
        chk("gap_index", a_index, 1);

        for (int n = 0; n < 40; n++) begin
            sel = $urandom_range(0, 9);
            if (hunting) begin
                if (sel < 2) begin
                    for (int i = 0; i < 8; i++)
                        send_bit(1'($urandom_range(0, 1)));
                end else begin
                    sync_start();
                end
            end else begin
                if (sel < 6) w = rand_led();
                else if (sel == 6) w = 32'd0;
                else if (sel == 7) w = 32'hFFFF_FFFF;
                else w = rand_bad();
                send_word(w);
            end
        end

        if (!hunting) send_word(32'hFFFF_FFFF);
        sync_start();
        for (int i = 0; i < 6; i++) send_word(rand_led());
        repeat (10) @(negedge clk);
        chk("sat_a", a_index, 5);
        chk("sat_b", b_index, 3);
        for (int i = 0; i < 10; i++) send_bit(1'($urandom_range(0, 1)));
        @(negedge clk);
        chk("pre_rst_q", q.size(), 0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_a", {a_blue, a_green, a_red, a_bright, a_index,
                          a_valid, a_start, a_end, a_err, a_busy}, 0);
        chk("mid_rst_b", {b_blue, b_green, b_red, b_bright, b_index,
                          b_valid, b_start, b_end, b_err, b_busy}, 0);
        hunting = 1'b1;
        zrun = 0;
        nb = 0;
        idx = 0;
        q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        sync_start();
        send_word(32'hE7C3_5A11);
        repeat (20) @(negedge clk);
        chk("post_rst", {a_bright, a_blue, a_index}, {5'h07, 8'hC3, 8'h00});
        chk("drain", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
